// File: rtl/ram_master.sv
// Burst master for a single-port synchronous RAM: one command becomes
// 1..16 single-cycle write or read strobes on consecutive addresses.
module ram_master #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_write,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned LEN_W = 4;
  // Every pending stage except the one currently presenting rdata_valid.
  localparam logic [RD_LAT-1:0] EARLY_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, wdata_ready_q, busy_q;
  logic                ram_write_q, ram_write_d;
  logic                ram_read_q, ram_read_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;

  // Next-state, burst bookkeeping and strobe generation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ram_write_d = 1'b0;
    ram_read_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    vld_d       = RD_LAT'({vld_q, ram_read_q});
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WR : RD;
        end
      end
      WR: begin
        if (wdata_valid) begin
          ram_write_d = 1'b1;
          ram_addr_d  = addr_q;
          ram_din_d   = wdata;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - LEN_W'(1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      RD: begin
        ram_read_d = 1'b1;
        ram_addr_d = addr_q;
        addr_d     = addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == '0) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave once only the final response (if any) is still on rdata_valid.
        if (!(ram_read_q || (|(vld_q & EARLY_MASK)))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_read_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      vld_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= (state_d == IDLE);
      wdata_ready_q <= (state_d == WR);
      busy_q        <= (state_d != IDLE);
      ram_write_q   <= ram_write_d;
      ram_read_q    <= ram_read_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      vld_q         <= vld_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign busy        = busy_q;
  assign ram_write   = ram_write_q;
  assign ram_read    = ram_read_q;
  assign ram_cs      = ram_write_q | ram_read_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  // Read data is taken straight from the RAM in the cycle the response is due.
  assign rdata_valid = vld_q[RD_LAT-1];
  assign rdata       = vld_q[RD_LAT-1] ? ram_dout : '0;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master: RD_LAT=1 instance with a 1-cycle RAM model
// and an RD_LAT=3 instance with a 3-cycle RAM model.
module tb_ram_master;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic          wdata_valid, wdata_ready, rdata_valid;
  logic [DW-1:0] wdata, rdata;
  logic          busy, ram_cs, ram_write, ram_read;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic          cmd_valid3, cmd_ready3, cmd_write3;
  logic [AW-1:0] cmd_addr3;
  logic [3:0]    cmd_len3;
  logic          wdata_valid3, wdata_ready3, rdata_valid3;
  logic [DW-1:0] wdata3, rdata3;
  logic          busy3, ram_cs3, ram_write3, ram_read3;
  logic [AW-1:0] ram_addr3;
  logic [DW-1:0] ram_din3, ram_dout3;

  ram_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy), .ram_cs(ram_cs),
    .ram_write(ram_write), .ram_read(ram_read), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout));

  ram_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write3), .cmd_addr(cmd_addr3), .cmd_len(cmd_len3),
    .wdata_valid(wdata_valid3), .wdata(wdata3), .wdata_ready(wdata_ready3),
    .rdata_valid(rdata_valid3), .rdata(rdata3), .busy(busy3), .ram_cs(ram_cs3),
    .ram_write(ram_write3), .ram_read(ram_read3), .ram_addr(ram_addr3),
    .ram_din(ram_din3), .ram_dout(ram_dout3));

  // RAM models: 1-cycle latency for dut, 3-cycle latency for dut3.
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] p1, p2;
  always @(posedge clk) begin
    if (ram_cs && ram_write) mem[ram_addr] <= ram_din;
    if (ram_cs && ram_read)  ram_dout <= mem[ram_addr];
    if (ram_cs3 && ram_read3) p1 <= mem3[ram_addr3];
    p2        <= p1;
    ram_dout3 <= p2;
  end

  int   n_total = 0;
  int   n_pass  = 0;
  logic excl_err = 1'b0;

  always @(negedge clk) begin
    if ((ram_write && ram_read) || (ram_cs !== (ram_write || ram_read)) ||
        (ram_write3 && ram_read3) || (ram_cs3 !== (ram_write3 || ram_read3)))
      excl_err = 1'b1;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          gap;
  } beat_t;
  beat_t vec [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [3:0] l);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wr_burst(input int first, input int n);
    send_cmd(1'b1, vec[first].addr, 4'(n - 1));
    check("wr_entry_wready", 32'(wdata_ready), 1);
    check("wr_entry_nostrobe", 32'(ram_cs), 0);
    for (int i = 0; i < n; i++) begin
      wdata_valid = 1'b1;
      wdata = vec[first+i].data;
      tick();
      wdata_valid = 1'b0;
      wdata = 8'hEE;
      check("wr_strobe", 32'({ram_cs, ram_write, ram_read}), 32'b110);
      check("wr_addr", 32'(ram_addr), 32'(vec[first+i].addr));
      check("wr_din", 32'(ram_din), 32'(vec[first+i].data));
      if (i == n - 1) begin
        check("wr_last_wready", 32'(wdata_ready), 0);
        check("wr_last_busy", 32'(busy), 0);
      end
      if (vec[first+i].gap || i == n - 1) begin
        tick();
        check("wr_gap_nostrobe", 32'(ram_cs), 0);
        check("wr_gap_hold_addr", 32'(ram_addr), 32'(vec[first+i].addr));
      end
    end
  endtask

  initial begin
    int   waits;
    logic bad;
    vec[0] = '{10'd0,    8'h01, 1'b0};
    vec[1] = '{10'd1,    8'h12, 1'b0};
    vec[2] = '{10'd2,    8'h13, 1'b0};
    vec[3] = '{10'd3,    8'h16, 1'b0};
    vec[4] = '{10'd4,    8'h02, 1'b0};
    vec[5] = '{10'd1022, 8'hA0, 1'b1};
    vec[6] = '{10'd1023, 8'hA1, 1'b1};
    vec[7] = '{10'd0,    8'hA2, 1'b1};
    vec[8] = '{10'd1,    8'hA3, 1'b1};
    mem3[5] = 8'hA5;

    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0;
    cmd_valid3 = 0; cmd_write3 = 0; cmd_addr3 = '0; cmd_len3 = '0;
    wdata_valid3 = 0; wdata3 = '0;

    #1;
    check("rst_outputs", 32'({wdata_ready, rdata_valid, busy, ram_cs, ram_write, ram_read}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr_din_rdata", 32'({ram_addr, ram_din, rdata}), 0);

    // Stray write data in IDLE does nothing.
    wdata_valid = 1'b1; wdata = 8'h55;
    tick();
    wdata_valid = 1'b0;
    check("idle_wdata_ignored", 32'({ram_cs, wdata_ready, busy}), 0);
    check("idle_din_hold", 32'(ram_din), 0);

    // Back-to-back write burst at 0..4.
    wr_burst(0, 5);

    // Read burst back, RD_LAT=1.
    send_cmd(1'b0, 10'd0, 4'd4);
    check("rd_entry_nostrobe", 32'(ram_cs), 0);
    check("rd_entry_busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) begin
        check("rd_strobe", 32'({ram_cs, ram_write, ram_read}), 32'b101);
        check("rd_addr", 32'(ram_addr), 32'(vec[i].addr));
      end else begin
        check("rd_strobe_end", 32'(ram_cs), 0);
        check("rd_drain_busy", 32'(busy), 1);
      end
      if (i > 0) begin
        check("rd_valid", 32'(rdata_valid), 1);
        check("rd_data", 32'(rdata), 32'(vec[i-1].data));
      end else begin
        check("rd_valid_early", 32'(rdata_valid), 0);
      end
    end
    tick();
    check("rd_done_valid", 32'(rdata_valid), 0);
    check("rd_done_busy", 32'(busy), 0);

    // Gapped write burst across the address wrap.
    wr_burst(5, 4);

    // Command held while busy with a read: accepted only once IDLE returns.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd0; cmd_len = 4'd2;
    tick();
    cmd_write = 1'b1; cmd_addr = 10'd100; cmd_len = 4'd0;
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      waits++;
      tick();
    end
    check("held_cmd_wait_cycles", 32'(waits), 5);
    tick();
    cmd_valid = 1'b0;
    check("held_cmd_accepted", 32'({busy, wdata_ready}), 32'b11);
    wdata_valid = 1'b1; wdata = 8'h77;
    tick();
    wdata_valid = 1'b0;
    check("held_cmd_write", 32'({ram_write, ram_addr, ram_din}), 32'({1'b1, 10'd100, 8'h77}));
    tick();

    // Reset in the 3rd read strobe of a len=7 read.
    send_cmd(1'b0, 10'd0, 4'd7);
    tick(); tick(); tick();
    check("abort_3rd_strobe", 32'({ram_read, ram_addr}), 32'({1'b1, 10'd2}));
    #2 rst = 1'b1;
    #1;
    check("abort_async_clear", 32'({ram_cs, ram_read, rdata_valid, busy}), 0);
    #2 rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rdata_valid || ram_cs) bad = 1'b1;
    end
    check("abort_no_activity", 32'(bad), 0);
    check("abort_cmd_ready", 32'(cmd_ready), 1);

    // RD_LAT=3, single-beat read.
    cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 10'd5; cmd_len3 = 4'd0;
    tick();
    cmd_valid3 = 1'b0;
    check("lat3_entry", 32'({busy3, ram_cs3}), 32'b10);
    tick();
    check("lat3_strobe", 32'({ram_read3, ram_addr3}), 32'({1'b1, 10'd5}));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("lat3_wait", 32'({rdata_valid3, ram_cs3, busy3}), 32'b001);
    end
    tick();
    check("lat3_valid", 32'({rdata_valid3, busy3}), 32'b11);
    check("lat3_data", 32'(rdata3), 32'h A5);
    tick();
    check("lat3_done", 32'({rdata_valid3, busy3, cmd_ready3}), 32'b001);

    check("strobe_exclusive", 32'(excl_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Parameters
REQ-001 SHALL provide: ADDR_W, default 10, width of the RAM address.
REQ-002 SHALL provide: DATA_W, default 8, width of the RAM data.
REQ-003 SHALL provide: RD_LAT, default 1, range 1..4, cycles from a read-strobe cycle to valid ram_dout.

Interface
REQ-004 SHALL have: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have: cmd_valid  in  1  command offered.
REQ-007 SHALL have: cmd_ready  out  1  command accepted this cycle when both are high.
REQ-008 SHALL have: cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-009 SHALL have: cmd_addr  in  ADDR_W  burst start address.
REQ-010 SHALL have: cmd_len  in  4  burst beats minus 1 (1..16 beats).
REQ-011 SHALL have: wdata_valid  in  1  write beat offered.
REQ-012 SHALL have: wdata  in  DATA_W  write beat data.
REQ-013 SHALL have: wdata_ready  out  1  write beat accepted when both are high.
REQ-014 SHALL have: rdata_valid  out  1  read beat present, one cycle each, no backpressure.
REQ-015 SHALL have: rdata  out  DATA_W  read beat data.
REQ-016 SHALL have: busy  out  1  high in every state except IDLE.
REQ-017 SHALL have: ram_cs, ram_write, ram_read  out  1 each  RAM strobes.
REQ-018 SHALL have: ram_addr  out  ADDR_W  RAM address.
REQ-019 SHALL have: ram_din  out  DATA_W  RAM write data.
REQ-020 SHALL have: ram_dout  in  DATA_W  RAM read data.

Function
REQ-021 SHALL use FSM states IDLE, WR, RD, DRAIN.
REQ-022 cmd_ready SHALL be 1 only in IDLE; a handshake latches addr, len and write, then moves to WR (write=1) or RD (write=0).
REQ-023 In WR, wdata_ready SHALL be 1; on each wdata handshake, the next cycle SHALL have ram_cs=ram_write=1, ram_addr=current address, ram_din=wdata, asserted for exactly that one cycle.
REQ-024 Cycles in WR without wdata_valid SHALL produce no strobes; the burst SHALL wait indefinitely.
REQ-025 After the handshake of beat cmd_len+1, wdata_ready SHALL drop and the FSM SHALL return to IDLE in the same edge; the final write strobe still appears in the following cycle.
REQ-026 In RD, ram_cs=ram_read=1 SHALL be asserted for exactly cmd_len+1 consecutive cycles, registered, starting the cycle after entry, with ram_addr incrementing each cycle.
REQ-027 After the last read strobe the FSM SHALL enter DRAIN, then return to IDLE the cycle after the last rdata_valid.
REQ-028 Each read-strobe cycle SHALL yield exactly one rdata_valid pulse RD_LAT cycles later, with rdata equal to ram_dout sampled at that point, in issue order; pending reads SHALL be tracked by an RD_LAT-deep valid shift register.
REQ-029 Address SHALL increment by 1 per beat modulo 2^ADDR_W; 1023 wraps to 0 with no error indication.
REQ-030 ram_write and ram_read SHALL never both be 1; ram_cs SHALL be 1 exactly when one of them is.
REQ-031 When no strobe is active, ram_addr and ram_din SHALL hold their last values.
REQ-032 A cmd_valid asserted while busy SHALL be ignored, with no effect until IDLE.
REQ-033 wdata_valid outside WR SHALL be ignored.

Reset
REQ-034 rst high SHALL immediately force: state IDLE; cmd_ready=1 (once rst is low); wdata_ready, rdata_valid, busy, ram_cs, ram_write, ram_read all 0; ram_addr, ram_din, rdata all 0.
REQ-035 Reset mid-burst SHALL abort the burst, discard in-flight read responses (shift register cleared), and produce no further strobes.

Verification
REQ-036 Write burst addr=0, len=4, wdata 01,12,13,16,02 back-to-back -> five 1-cycle write strobes at addr 0..4 with matching ram_din, then IDLE.
REQ-037 Read burst addr=0, len=4 against a 1-cycle-latency RAM model preloaded with REQ-036 data, RD_LAT=1 -> read strobes for 5 consecutive cycles; rdata 01,12,13,16,02 each 1 cycle after its strobe; busy falls after the last beat.
REQ-038 Write burst addr=1022, len=3 with wdata_valid gapped every other cycle -> strobes only after accepted beats; addresses 1022, 1023, 0, 1.
REQ-039 rst pulsed during the 3rd read strobe of a len=7 read -> all strobes and rdata_valid go 0 asynchronously; no rdata_valid afterwards; cmd_ready=1 after rst falls.
REQ-040 cmd_valid held during a busy read -> cmd_ready stays 0; new command accepted on the first IDLE cycle; assert ram_write & ram_read never both high throughout.
REQ-041 RD_LAT=3, read len=0 -> one strobe; rdata_valid exactly 3 cycles later; DRAIN lasts until then.
